// File: rtl/rgb_processor.sv
// rgb_processor: three independent 8-bit colour channel registers.
//
// Each rising edge, in priority order:
//   rst               -> all channels cleared to 8'h00
//   write_enable_init -> channels loaded from r_in/g_in/b_in
//   otherwise         -> every channel steps by its own STEP_x, adding when s=0 and
//                        subtracting when s=1. With SATURATE=1 results clamp to
//                        8'h00/8'hFF; with SATURATE=0 they wrap modulo 256.
//
// Parameters:
//   STEP_R/STEP_G/STEP_B  per-channel step size (0 holds that channel while stepping)
//   SATURATE              1 = clamp at 0/255, 0 = modulo-256 wrap
//
// Ports:
//   clk                   sole clock, rising edge
//   rst                   synchronous active-high reset
//   r_in/g_in/b_in        load values
//   write_enable_init     load strobe
//   s                     step direction: 0 = add, 1 = subtract
//   r_out/g_out/b_out     channel registers, driven straight from flops
module rgb_processor #(
  parameter logic [7:0] STEP_R   = 8'd1,
  parameter logic [7:0] STEP_G   = 8'd1,
  parameter logic [7:0] STEP_B   = 8'd1,
  parameter bit         SATURATE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  input  logic       write_enable_init,
  input  logic       s,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out
);

  logic [7:0] r_q, r_d;
  logic [7:0] g_q, g_d;
  logic [7:0] b_q, b_d;

  // One channel step computed at 9 bits. Bit 8 is the carry on add and the
  // borrow on subtract, so it doubles as the out-of-range flag for clamping.
  function automatic logic [7:0] step_chan(input logic [7:0] cur,
                                           input logic [7:0] step,
                                           input logic       sub);
    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] res;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    if (sub) begin
      res = (SATURATE && diff[8]) ? 8'h00 : diff[7:0];
    end else begin
      res = (SATURATE && sum[8]) ? 8'hFF : sum[7:0];
    end
    return res;
  endfunction

  always_comb begin
    r_d = r_q;
    g_d = g_q;
    b_d = b_q;
    if (write_enable_init) begin
      r_d = r_in;
      g_d = g_in;
      b_d = b_in;
    end else begin
      r_d = step_chan(r_q, STEP_R, s);
      g_d = step_chan(g_q, STEP_G, s);
      b_d = step_chan(b_q, STEP_B, s);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= 8'h00;
      g_q <= 8'h00;
      b_q <= 8'h00;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;

endmodule

// File: tb/tb_rgb_processor.sv
// Self-checking bench for rgb_processor. Three instances share one stimulus:
//   dut_sat  defaults (step 1, saturating)
//   dut_wrap step 1, modulo-256 wrap
//   dut_mix  steps 3/0/200, saturating
// Expected values come from an integer-arithmetic model, are queued when stimulus
// is applied and compared one step after the clock edge.
module tb_rgb_processor;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic       s;
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] ra, ga, ba;
  logic [7:0] rb, gb, bb;
  logic [7:0] rc, gc, bc;

  always #5 clk = ~clk;

  rgb_processor dut_sat (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .write_enable_init(we), .s(s), .r_out(ra), .g_out(ga), .b_out(ba)
  );

  rgb_processor #(.SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .write_enable_init(we), .s(s), .r_out(rb), .g_out(gb), .b_out(bb)
  );

  rgb_processor #(.STEP_R(8'd3), .STEP_G(8'd0), .STEP_B(8'd200), .SATURATE(1'b1)) dut_mix (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .write_enable_init(we), .s(s), .r_out(rc), .g_out(gc), .b_out(bc)
  );

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;
  } exp_t;

  exp_t        exp_q[$];
  logic [23:0] ma = 24'h0, mb = 24'h0, mc = 24'h0;
  int          checks = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ch(input logic [7:0] cur, input int step,
                                          input bit sat, input bit sub);
    int v;
    v = sub ? int'(cur) - step : int'(cur) + step;
    if (sat) begin
      if (v > 255) v = 255;
      if (v < 0) v = 0;
    end else begin
      v = (v + 256) % 256;
    end
    return v[7:0];
  endfunction

  function automatic logic [23:0] model_next(input logic [23:0] cur, input int sr, input int sg,
                                             input int sbl, input bit sat);
    if (rst) return 24'h0;
    if (we) return {r_in, g_in, b_in};
    return {model_ch(cur[23:16], sr, sat, s), model_ch(cur[15:8], sg, sat, s),
            model_ch(cur[7:0], sbl, sat, s)};
  endfunction

  task automatic cycle(input string tag);
    exp_t e;
    exp_t got;
    e.a = model_next(ma, 1, 1, 1, 1'b1);
    e.b = model_next(mb, 1, 1, 1, 1'b0);
    e.c = model_next(mc, 3, 0, 200, 1'b1);
    ma = e.a;
    mb = e.b;
    mc = e.c;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = exp_q.pop_front();
    check({tag, "/sat"}, {ra, ga, ba}, got.a);
    check({tag, "/wrap"}, {rb, gb, bb}, got.b);
    check({tag, "/mix"}, {rc, gc, bc}, got.c);
  endtask

  task automatic load(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic dir, input string tag);
    we = 1'b1; s = dir; r_in = r; g_in = g; b_in = b;
    cycle(tag);
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; s = 1'b0; r_in = 8'h0; g_in = 8'h0; b_in = 8'h0;
    cycle("reset");
    check("reset_const", {ra, ga, ba}, 24'h000000);
    rst = 1'b0;

    // Count up from zero, then down into the floor.
    load(8'h00, 8'h00, 8'h00, 1'b0, "load0");
    cycle("up1");
    check("up1_const", {ra, ga, ba}, 24'h010101);
    check("mix_up1_const", {rc, gc, bc}, 24'h0300C8);
    cycle("up2");
    check("up2_const", {ra, ga, ba}, 24'h020202);
    check("mix_up2_const", {rc, gc, bc}, 24'h0600FF);
    s = 1'b1;
    cycle("dn1");
    check("dn1_const", {ra, ga, ba}, 24'h010101);
    cycle("dn2");
    cycle("dn3");
    check("dn3_floor_const", {ra, ga, ba}, 24'h000000);

    // Outputs must not move on rst alone between edges.
    s = 1'b0;
    load(8'h44, 8'h55, 8'h66, 1'b0, "pre_rst");
    rst = 1'b1;
    #2;
    check("no_edge_sat", {ra, ga, ba}, ma);
    check("no_edge_mix", {rc, gc, bc}, mc);
    cycle("rst_edge");
    rst = 1'b0;

    // Red clamps at FF while green and blue keep counting.
    load(8'hFE, 8'h80, 8'h00, 1'b0, "load_fe");
    cycle("clamp1");
    check("clamp1_const", {ra, ga, ba}, 24'hFF8101);
    cycle("clamp2");
    check("clamp2_const", {ra, ga, ba}, 24'hFF8202);

    // Wrap-around in both directions on the modulo instance.
    load(8'hFF, 8'h00, 8'h10, 1'b0, "load_ff");
    cycle("wrap_up");
    check("wrap_up_const", {rb, gb, bb}, 24'h000111);
    s = 1'b1;
    cycle("wrap_dn1");
    check("wrap_dn1_const", {rb, gb, bb}, 24'hFF0010);
    cycle("wrap_dn2");
    check("wrap_dn2_const", {rb, gb, bb}, 24'hFEFF0F);

    // Load beats step.
    load(8'h55, 8'hAA, 8'h33, 1'b1, "load_beats_step");
    check("load_beats_step_const", {ra, ga, ba}, 24'h55AA33);

    // Reset beats load mid-count, then stepping resumes from zero.
    s = 1'b0;
    cycle("count_a");
    cycle("count_b");
    rst = 1'b1; we = 1'b1; r_in = 8'h12; g_in = 8'h34; b_in = 8'h56;
    cycle("rst_beats_load");
    check("rst_beats_load_const", {ra, ga, ba}, 24'h000000);
    rst = 1'b0; we = 1'b0;
    cycle("resume");
    check("resume_const", {ra, ga, ba}, 24'h010101);

    // Random mix of loads, direction changes and occasional resets.
    for (int i = 0; i < 80; i++) begin
      rst  = ($urandom_range(0, 19) == 0);
      we   = ($urandom_range(0, 4) == 0);
      s    = $urandom_range(0, 1);
      r_in = 8'($urandom_range(0, 255));
      g_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rgb_processor.md
RGB_PROCESSOR -- requirements
Module: rgb_processor

Interface
REQ-001 Parameter STEP_R, default 8'd1: red channel increment/decrement per cycle.
REQ-002 Parameter STEP_G, default 8'd1: green channel increment/decrement per cycle.
REQ-003 Parameter STEP_B, default 8'd1: blue channel increment/decrement per cycle.
REQ-004 Parameter SATURATE, default 1: 1 = clamp at 0/255, 0 = modulo-256 wrap.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 r_in  input  8  red load value.
REQ-009 g_in  input  8  green load value.
REQ-010 b_in  input  8  blue load value.
REQ-011 write_enable_init  input  1  load r_in/g_in/b_in into channel registers.
REQ-012 s  input  1  mode select: 0 = add step, 1 = subtract step.
REQ-013 r_out  output  8  red channel register.
REQ-014 g_out  output  8  green channel register.
REQ-015 b_out  output  8  blue channel register.

Function
REQ-016 Three independent 8-bit channel registers SHALL drive r_out/g_out/b_out directly (registered outputs, no combinational path from inputs).
REQ-017 Priority per rising edge SHALL be: rst > write_enable_init > step operation.
REQ-018 write_enable_init=1 SHALL load all three inputs in that cycle; new values visible on outputs after that edge (1-cycle latency).
REQ-019 write_enable_init=0, s=0 SHALL set each channel to channel + STEP_x on every edge.
REQ-020 write_enable_init=0, s=1 SHALL set each channel to channel - STEP_x on every edge.
REQ-021 Arithmetic SHALL be computed at 9 bits; with SATURATE=1, sums > 255 clamp to 8'hFF and differences < 0 clamp to 8'h00.
REQ-022 With SATURATE=0, results SHALL wrap modulo 256 (8'hFF + 1 = 8'h00; 8'h00 - 1 = 8'hFF).
REQ-023 Channels SHALL update independently; one channel saturating SHALL NOT affect the others.
REQ-024 A change of s SHALL take effect on the next rising edge; no idle/transition cycle.
REQ-025 A channel at its bound SHALL hold (saturating mode) while the operation continues pushing past it.
REQ-026 STEP_x = 0 SHALL hold that channel constant in step operation.

Reset
REQ-027 rst=1 at a rising edge SHALL clear r_out, g_out, b_out to 8'h00, overriding write_enable_init and s.
REQ-028 Reset asserted mid-operation SHALL clear on the next edge; stepping resumes from 0 on the first edge after deassertion.
REQ-029 No output SHALL change between edges or on rst alone without a clock edge.

Verification
REQ-030 rst 1 cycle; load 0/0/0 with s=0, then 2 edges -> outputs 01/01/01 then 02/02/02 (defaults).
REQ-031 From 02/02/02 set s=1, 3 edges -> 01, 00, 00 on all channels (saturate at 0).
REQ-032 Load FE/80/00, s=0, 2 edges -> FF/81/01 then FF/82/02 (red clamps at FF).
REQ-033 SATURATE=0: load FF/00/10, s=0, 1 edge -> 00/01/11; s=1, 2 edges -> FF/00/10 then FE/FF/0F.
REQ-034 write_enable_init=1 with s=1 and inputs 55/AA/33 -> outputs 55/AA/33 next edge (load beats step).
REQ-035 Assert rst together with write_enable_init=1 (inputs 12/34/56) mid-count -> outputs 00/00/00 next edge.
